ball_frame_tracker: RTL

//  Watches the ball-pixel video stream, one pixel per clk, from the ball generator and recovers per-frame ball state.
//  - Per frame it reports: top-left ball coordinate, validity and a lost flag.
//  - Optional: per-frame velocity.
//  - Sits beside the video path; results feed scoring and paddle-AI logic.

---
 rtl/ball_frame_tracker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ball_frame_tracker.sv
// ball_frame_tracker: recovers per-frame ball position, validity and
// loss status from the ball-pixel video stream (one pixel per clk).
// Optional velocity output: define BALL_TRACK_VELOCITY_EN.
// Ports:
//   clk, ball_reset         pixel clock, async active-high reset
//   vsync, display_on       sync / active-video qualifiers
//   hpos, vpos              current beam column / row
//   ball_pix                ball graphic bit
//   ball_x, ball_y          top-left ball pixel of last valid frame
//   ball_valid, ball_lost   frame validity, consecutive-miss flag
//   frame_strobe            one-clk pulse while results are reported
//   vel_x, vel_y            signed 4-bit per-frame motion (0 if disabled)
module ball_frame_tracker #(
  parameter int H_BITS     = 9,
  parameter int V_BITS     = 9,
  parameter int MIN_PIXELS = 4,
  parameter int MAX_MISS   = 3
) (
  input  logic              clk,
  input  logic              ball_reset,
  input  logic              vsync,
  input  logic              display_on,
  input  logic [H_BITS-1:0] hpos,
  input  logic [V_BITS-1:0] vpos,
  input  logic              ball_pix,
  output logic [H_BITS-1:0] ball_x,
  output logic [V_BITS-1:0] ball_y,
  output logic              ball_valid,
  output logic              ball_lost,
  output logic              frame_strobe,
  output logic [3:0]        vel_x,
  output logic [3:0]        vel_y
);

  localparam logic [7:0] MIN_CNT  = 8'(MIN_PIXELS);
  localparam logic [2:0] MISS_LIM = 3'(MAX_MISS);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t            state;
  logic              vs_q;
  logic              vs_rise;
  logic              vs_rise_q;
  logic [7:0]        cnt;
  logic [H_BITS-1:0] min_x;
  logic [V_BITS-1:0] min_y;
  logic [2:0]        miss;
  logic [2:0]        miss_next;
  logic              hit;
  logic              frame_ok;

  assign vs_rise = vsync & ~vs_q;

  // The frame boundary is registered once before REPORT, so neither
  // the rise cycle nor the cycle after it contributes pixels.
  assign hit = (state == SCAN) & display_on & ball_pix
             & ~vs_rise & ~vs_rise_q;

  assign frame_ok = (cnt >= MIN_CNT);

  always_comb begin
    miss_next = miss;
    if (frame_ok)
      miss_next = 3'd0;
    else if (miss != 3'd7)
      miss_next = miss + 3'd1;
  end

  always_ff @(posedge clk or posedge ball_reset) begin
    if (ball_reset) begin
      state        <= IDLE;
      vs_q         <= 1'b0;
      vs_rise_q    <= 1'b0;
      cnt          <= 8'd0;
      min_x        <= '1;
      min_y        <= '1;
      miss         <= 3'd0;
      ball_x       <= '0;
      ball_y       <= '0;
      ball_valid   <= 1'b0;
      ball_lost    <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      vs_q         <= vsync;
      vs_rise_q    <= (state == SCAN) & vs_rise;
      frame_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (vs_rise)
            state <= SCAN;
        end
        SCAN: begin
          if (hit) begin
            if (cnt != 8'hff)
              cnt <= cnt + 8'd1;
            if (hpos < min_x)
              min_x <= hpos;
            if (cnt == 8'd0)
              min_y <= vpos;
          end
          if (vs_rise_q) begin
            state        <= REPORT;
            frame_strobe <= 1'b1;
          end
        end
        REPORT: begin
          if (frame_ok) begin
            ball_x <= min_x;
            ball_y <= min_y;
          end
          ball_valid <= frame_ok;
          miss       <= miss_next;
          ball_lost  <= (miss_next >= MISS_LIM);
          cnt        <= 8'd0;
          min_x      <= '1;
          min_y      <= '1;
          state      <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BALL_TRACK_VELOCITY_EN
  logic                     prev_valid;
  logic signed [H_BITS:0]   dx;
  logic signed [V_BITS:0]   dy;

  // One extra bit keeps the difference of two unsigned coords exact.
  assign dx = $signed({1'b0, min_x}) - $signed({1'b0, ball_x});
  assign dy = $signed({1'b0, min_y}) - $signed({1'b0, ball_y});

  function automatic logic [3:0] clamp_h(
    input logic signed [H_BITS:0] d
  );
    if (d > 7)
      return 4'd7;
    else if (d < -8)
      return 4'd8;
    else
      return 4'(d);
  endfunction

  function automatic logic [3:0] clamp_v(
    input logic signed [V_BITS:0] d
  );
    if (d > 7)
      return 4'd7;
    else if (d < -8)
      return 4'd8;
    else
      return 4'(d);
  endfunction

  always_ff @(posedge clk or posedge ball_reset) begin
    if (ball_reset) begin
      prev_valid <= 1'b0;
      vel_x      <= 4'd0;
      vel_y      <= 4'd0;
    end else if (state == REPORT) begin
      prev_valid <= frame_ok;
      if (frame_ok && prev_valid) begin
        vel_x <= clamp_h(dx);
        vel_y <= clamp_v(dy);
      end else begin
        vel_x <= 4'd0;
        vel_y <= 4'd0;
      end
    end
  end
`else
  assign vel_x = 4'd0;
  assign vel_y = 4'd0;
`endif

endmodule
